trigger_readout_sched: RTL and testbench
========================================

Name: trigger_readout_sched

Overview:
- Multi-channel readout scheduler for the trigger timestamp datapath.
- Detects rising edges on N trigger inputs and stamps each with the free-running master counter value.
- Round-robin arbitration feeds the tagged events into a small FIFO.
- Sequences the serial readout (DAT_ENA/DAT_CLK/DAT_OUT) and drives DAT_RDY, which the single-channel path ties to 0.

Parameters:
- CNT_WIDTH, 24, width of the master counter / timestamp field.
- N_CH, 4, number of trigger channels (power of two, 2..8).
- CH_W, 2, channel-id width; must equal log2(N_CH).
- FIFO_DEPTH, 4, event FIFO entries (power of two).
- OUT_WORD_WIDTH, 27, serial word width; must equal 1+CH_W+CNT_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cnt  in  CNT_WIDTH  master counter value.
- trigg  in  N_CH  trigger inputs, already synchronous to clk.
- dat_ena  in  1  host frame enable.
- dat_clk  in  1  host serial clock, oversampled by clk.
- dat_rdy  out  1  FIFO non-empty.
- dat_out  out  1  serial data, MSB first.
- ovf  out  1  sticky drop flag.

Behaviour:
- Reset: asynchronous, active-low. Clears:
  - all pending slots, FIFO pointers and count, shift register, and edge-detect history (prev_* = 0);
  - rr pointer = 0, ovf = 0, FSM = IDLE.
  - dat_rdy = 0 and dat_out = 0 while in reset.
  - A reset in the middle of a frame aborts the frame with no pop.
- Edge detect:
  - A rising edge on channel i is trigg[i]=1 while prev_trigg[i]=0, sampled at clock edge E0.
  - At E0, pend_vld[i] is set and pend_ts[i] = cnt as sampled at E0.
  - If pend_vld[i] is already 1 at E0, the event is dropped: ovf_pend[i] is set and the global ovf is set (sticky until reset).
- Arbiter: each cycle, grant one valid pending slot.
  - Search starts at index rr and wraps round-robin.
  - Grant only if the FIFO can accept the entry: count<FIFO_DEPTH, or a pop occurs in the same cycle.
  - On grant, push entry {ovf_pend[i], i, pend_ts[i]}, clear pend_vld[i] and ovf_pend[i], and set rr = i+1 mod N_CH.
  - A slot that is granted and receives a new edge in the same cycle keeps the new event: pend_vld stays 1 with the new ts, and there is no overflow.
- Latency: edge sampled at E0 → FIFO write at E1 → dat_rdy=1 after E1, i.e. 2 clocks. Simultaneous edges on k channels drain in k consecutive cycles.
- FIFO: synchronous, registered count. dat_rdy = (count!=0), registered.
  - A push into a full FIFO with no pop never occurs; the pending slot waits.
  - Pointers wrap modulo FIFO_DEPTH.
- Readout FSM, states IDLE, SHIFT:
  - IDLE: on dat_ena rising edge (dat_ena=1, prev_ena=0):
    - load shreg with the FIFO head if count!=0 and set loaded=1;
    - otherwise load all zeros and set loaded=0;
    - then go to SHIFT.
  - SHIFT: on dat_clk falling edge (prev=1, now=0), shreg <<= 1 with zero fill. After OUT_WORD_WIDTH shifts dat_out stays 0.
  - SHIFT: on dat_ena falling edge, pop the FIFO if loaded=1, then go to IDLE. Any dat_clk edge in that same cycle is ignored.
  - dat_out = shreg[MSB], registered.
  - The head is not removed until frame end, so an aborted frame by host timing still consumes the entry; dat_ena low means the host is done.
  - A pop and a push in the same cycle leave count unchanged.
- Word format, MSB→LSB: [ovf bit][channel id CH_W][timestamp CNT_WIDTH].
- Timestamp wrap: cnt rolls over naturally. No correction; the host unwraps.

Decomposition:
- Package trigger_pkg:
  - localparams CNT_WIDTH, N_CH, CH_W, FIFO_DEPTH;
  - typedef packed struct evt_t {logic ovf; logic [CH_W-1:0] ch; logic [CNT_WIDTH-1:0] ts;}.
- One sub-module, evt_fifo: parameterised synchronous FIFO of evt_t with push/pop/count/empty/full.
- Arbiter, edge detect and readout FSM stay in the top.

Test Plan:
- Single event:
  - Stimulus: cnt=0x000100 at edge, pulse trigg[2].
  - Required response: dat_rdy rises 2 clocks later. A 27-clock frame reads 0b0_10_000000000000000100000000. After dat_ena falls, dat_rdy=0.
- Simultaneous edges:
  - Stimulus: trigg=4'b1011 at cnt=0x55, rr=0.
  - Required response: FIFO receives ch0, ch1, ch3 in consecutive cycles, all ts=0x55. Three frames return them in that order; next rr=0.
- Overflow:
  - Stimulus: fill the FIFO with 4 events, then 2 more edges on ch1 with no readout.
  - Required response: the second ch1 edge is dropped and ovf=1. After one pop, ch1 enters the FIFO with ovf bit=1, and the later frame shows MSB=1.
- Empty read:
  - Stimulus: dat_ena frame with count=0.
  - Required response: dat_out=0 for all bits, no pop, count stays 0, pointers unchanged.
- Push/pop collision:
  - Stimulus: FIFO full and a pending ch0 event; drop dat_ena.
  - Required response: in the same cycle, pop plus push of ch0; count stays 4.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during shift bit 10.
  - Required response: dat_out=0, dat_rdy=0, ovf=0 immediately (asynchronous). After release, the FSM is in IDLE and the FIFO is empty.

Source files
------------

// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared sizes, event record and readout states for the trigger scheduler
package trigger_pkg;

  localparam int CNT_WIDTH      = 24;
  localparam int N_CH           = 4;
  localparam int CH_W           = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int OUT_WORD_WIDTH = 1 + CH_W + CNT_WIDTH;
  localparam int FCNT_W         = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic            ovf;
    logic [CH_W-1:0] ch;
    logic [CNT_WIDTH-1:0] ts;
  } evt_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rd_state_t;

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous event FIFO with registered count/empty/full
module evt_fifo
  import trigger_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  evt_t          wdata,
  input  logic          pop,
  output evt_t          rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/trigger_readout_sched.sv
// rtl/trigger_readout_sched.sv - trigger edge stamping, round-robin arbitration and serial readout
module trigger_readout_sched
  import trigger_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [N_CH-1:0]      trigg,
  input  logic                 dat_ena,
  input  logic                 dat_clk,
  output logic                 dat_rdy,
  output logic                 dat_out,
  output logic                 ovf
);

  logic [N_CH-1:0]      prev_trigg;
  logic [N_CH-1:0]      rise;
  logic [N_CH-1:0]      pend_vld;
  logic [N_CH-1:0]      ovf_pend;
  logic [N_CH-1:0]      gnt_oh;
  logic [CNT_WIDTH-1:0] pend_ts [N_CH];
  logic [CH_W-1:0]      rr;
  logic [CH_W-1:0]      gnt_idx;
  logic [CH_W-1:0]      srch_idx;
  logic                 gnt_any;
  logic                 grant;

  evt_t                 fifo_wdata;
  evt_t                 fifo_head;
  logic [FCNT_W-1:0]    fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;

  rd_state_t            state;
  logic                 prev_ena;
  logic                 prev_dclk;
  logic                 loaded;
  logic                 pop;
  logic                 ena_rise;
  logic                 ena_fall;
  logic                 dclk_fall;
  logic [OUT_WORD_WIDTH-1:0] shreg;

  assign rise      = trigg & ~prev_trigg;
  assign ena_rise  = dat_ena && !prev_ena;
  assign ena_fall  = !dat_ena && prev_ena;
  assign dclk_fall = !dat_clk && prev_dclk;
  assign pop       = (state == ST_SHIFT) && ena_fall && loaded;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      srch_idx = rr + CH_W'(k);
      if (!gnt_any && pend_vld[srch_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = srch_idx;
      end
    end
    grant  = gnt_any && (!fifo_full || pop);
    gnt_oh = '0;
    if (grant) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign fifo_wdata = evt_t'{ovf: ovf_pend[gnt_idx], ch: gnt_idx, ts: pend_ts[gnt_idx]};

  evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A slot drained this cycle is free again, so a coincident edge refills it cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_trigg <= '0;
      pend_vld   <= '0;
      ovf_pend   <= '0;
      rr         <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        pend_ts[i] <= '0;
      end
    end else begin
      prev_trigg <= trigg;
      if (grant) begin
        rr <= gnt_idx + CH_W'(1);
      end
      if (|(rise & pend_vld & ~gnt_oh)) begin
        ovf <= 1'b1;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i] && (!pend_vld[i] || gnt_oh[i])) begin
          pend_vld[i] <= 1'b1;
          pend_ts[i]  <= cnt;
          ovf_pend[i] <= 1'b0;
        end else if (rise[i]) begin
          ovf_pend[i] <= 1'b1;
        end else if (gnt_oh[i]) begin
          pend_vld[i] <= 1'b0;
          ovf_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prev_ena  <= 1'b0;
      prev_dclk <= 1'b0;
      loaded    <= 1'b0;
      shreg     <= '0;
    end else begin
      prev_ena  <= dat_ena;
      prev_dclk <= dat_clk;
      case (state)
        ST_IDLE: begin
          if (ena_rise) begin
            shreg  <= (fifo_count != '0) ? fifo_head : '0;
            loaded <= (fifo_count != '0);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Frame end wins over a coincident dat_clk edge; the head leaves only now.
          if (ena_fall) begin
            shreg  <= '0;
            loaded <= 1'b0;
            state  <= ST_IDLE;
          end else if (dclk_fall) begin
            shreg <= {shreg[OUT_WORD_WIDTH-2:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dat_out = shreg[OUT_WORD_WIDTH-1];
  assign dat_rdy = !fifo_empty;

endmodule

// File: tb/tb_trigger_readout_sched.sv
// tb/tb_trigger_readout_sched.sv - table, directed and randomized checks of trigger_readout_sched
module tb_trigger_readout_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] cnt = '0;
  logic [3:0]  trigg = '0;
  logic        dat_ena = 1'b0;
  logic        dat_clk = 1'b0;
  logic        dat_rdy;
  logic        dat_out;
  logic        ovf;

  always #5 clk = ~clk;

  trigger_readout_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (cnt),
    .trigg   (trigg),
    .dat_ena (dat_ena),
    .dat_clk (dat_clk),
    .dat_rdy (dat_rdy),
    .dat_out (dat_out),
    .ovf     (ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending events per channel, FIFO as a queue of readout words.
  logic [3:0]  m_prev_trigg;
  logic [3:0]  m_pend;
  logic [3:0]  m_povf;
  logic [23:0] m_ts [4];
  logic [26:0] m_fifo [$];
  int          m_rr;
  logic        m_ovf;
  logic        m_in_frame;
  logic        m_loaded;
  logic        m_prev_ena;
  logic        m_prev_dclk;
  logic [26:0] m_word;

  task automatic model_reset();
    m_prev_trigg = '0;
    m_pend       = '0;
    m_povf       = '0;
    for (int i = 0; i < 4; i++) m_ts[i] = '0;
    m_fifo.delete();
    m_rr        = 0;
    m_ovf       = 1'b0;
    m_in_frame  = 1'b0;
    m_loaded    = 1'b0;
    m_prev_ena  = 1'b0;
    m_prev_dclk = 1'b0;
    m_word      = '0;
  endtask

  task automatic model_step();
    logic popped;
    logic granted;
    int   g;
    int   sz;
    logic [3:0] rise;
    sz = m_fifo.size();
    popped = m_in_frame && !dat_ena && m_prev_ena && m_loaded;
    granted = 1'b0;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      if (!granted && m_pend[(m_rr + k) % 4]) begin
        granted = 1'b1;
        g = (m_rr + k) % 4;
      end
    end
    if (granted && !(sz < 4 || popped)) granted = 1'b0;
    if (!m_in_frame) begin
      if (dat_ena && !m_prev_ena) begin
        m_word     = (sz != 0) ? m_fifo[0] : 27'd0;
        m_loaded   = (sz != 0);
        m_in_frame = 1'b1;
      end
    end else if (!dat_ena && m_prev_ena) begin
      if (m_loaded) void'(m_fifo.pop_front());
      m_in_frame = 1'b0;
      m_loaded   = 1'b0;
      m_word     = '0;
    end else if (!dat_clk && m_prev_dclk) begin
      m_word = m_word << 1;
    end
    if (granted) begin
      m_fifo.push_back({m_povf[g], 2'(g), m_ts[g]});
      m_rr = (g + 1) % 4;
    end
    rise = trigg & ~m_prev_trigg;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        if (!m_pend[i] || (granted && g == i)) begin
          m_pend[i] = 1'b1;
          m_ts[i]   = cnt;
          m_povf[i] = 1'b0;
        end else begin
          m_povf[i] = 1'b1;
          m_ovf     = 1'b1;
        end
      end else if (granted && g == i) begin
        m_pend[i] = 1'b0;
        m_povf[i] = 1'b0;
      end
    end
    m_prev_trigg = trigg;
    m_prev_ena   = dat_ena;
    m_prev_dclk  = dat_clk;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_rdy", dat_rdy, m_fifo.size() != 0);
    check("model_dout", dat_out, m_word[26]);
    check("model_ovf", ovf, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rdy", dat_rdy, 0);
    check("rst_dout", dat_out, 0);
    check("rst_ovf", ovf, 0);
    model_reset();
    trigg   = '0;
    dat_ena = 1'b0;
    dat_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_frame(output logic [26:0] w);
    w = '0;
    dat_ena = 1'b1;
    dat_clk = 1'b0;
    cycle();
    w[26] = dat_out;
    for (int b = 25; b >= 0; b--) begin
      dat_clk = 1'b1;
      cycle();
      dat_clk = 1'b0;
      cycle();
      w[b] = dat_out;
    end
    dat_ena = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [3:0]  trigg;
    logic [23:0] cnt;
    logic        ena;
    logic        dclk;
    logic        exp_rdy;
    logic        exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t        tbl [4];
  logic [26:0] w;
  logic [26:0] exp_words [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'h0, 24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'h4, 24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'h0, 24'h000101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'h0, 24'h000102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #1;
    do_reset();

    read_frame(w);
    check("empty_word", w, 27'd0);
    check("empty_rdy", dat_rdy, 0);

    for (int i = 0; i < 4; i++) begin
      trigg   = tbl[i].trigg;
      cnt     = tbl[i].cnt;
      dat_ena = tbl[i].ena;
      dat_clk = tbl[i].dclk;
      cycle();
      check($sformatf("tbl%0d_rdy", i), dat_rdy, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_dout", i), dat_out, tbl[i].exp_out);
      check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].exp_ovf);
    end
    read_frame(w);
    check("single_word", w, 27'h2000100);
    check("single_rdy_after", dat_rdy, 0);

    do_reset();
    cnt = 24'h55;
    trigg = 4'b1011;
    cycle();
    trigg = '0;
    cnt = 24'h56;
    repeat (4) cycle();
    exp_words[0] = 27'h0000055;
    exp_words[1] = 27'h1000055;
    exp_words[2] = 27'h3000055;
    for (int i = 0; i < 3; i++) begin
      read_frame(w);
      check($sformatf("simul_word%0d", i), w, exp_words[i]);
    end
    cnt = 24'h66;
    trigg = 4'b1001;
    cycle();
    trigg = '0;
    repeat (3) cycle();
    read_frame(w);
    check("rr_wrap_first", w, 27'h0000066);
    read_frame(w);
    check("rr_wrap_second", w, 27'h3000066);
    check("rr_wrap_rdy", dat_rdy, 0);

    do_reset();
    cnt = 24'h10;
    trigg = 4'hF;
    cycle();
    trigg = '0;
    repeat (4) cycle();
    cnt = 24'h20;
    trigg = 4'h2;
    cycle();
    trigg = '0;
    cnt = 24'h21;
    cycle();
    check("ovf_before_drop", ovf, 0);
    trigg = 4'h2;
    cnt = 24'h22;
    cycle();
    check("ovf_after_drop", ovf, 1);
    trigg = '0;
    cycle();
    exp_words[0] = 27'h0000010;
    exp_words[1] = 27'h1000010;
    exp_words[2] = 27'h2000010;
    exp_words[3] = 27'h3000010;
    exp_words[4] = 27'h5000020;
    for (int i = 0; i < 5; i++) begin
      read_frame(w);
      check($sformatf("ovf_word%0d", i), w, exp_words[i]);
    end
    check("ovf_drain_rdy", dat_rdy, 0);
    check("ovf_sticky", ovf, 1);

    cnt = 24'hFFFFFF;
    trigg = 4'h1;
    cycle();
    trigg = '0;
    repeat (2) cycle();
    dat_ena = 1'b1;
    cycle();
    for (int s = 0; s < 10; s++) begin
      dat_clk = 1'b1;
      cycle();
      dat_clk = 1'b0;
      cycle();
    end
    check("midframe_dout", dat_out, 1);
    #2;
    do_reset();
    read_frame(w);
    check("post_reset_word", w, 27'd0);
    check("post_reset_rdy", dat_rdy, 0);

    cnt = 24'hFFFFF0;
    for (int n = 0; n < 3000; n++) begin
      cnt   = cnt + 24'd1;
      trigg = 4'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) dat_ena = ~dat_ena;
      dat_clk = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
